// File: rtl/mult_div_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM state
// type and the default iteration count.
package mult_div_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam int ITER_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/md_sign_fix.sv
// Combinational sign handling around the unsigned iterative datapath.
//   Front end: op_i/a_i/b_i -> operand magnitudes and their sign flags
//              (flags are forced to 0 for the unsigned ops).
//   Back end : rop_i/rneg_a_i/rneg_b_i/raw_i -> signed-corrected hi_o/lo_o.
//              raw_i is {hi,lo} of the magnitude product, or
//              {remainder, quotient} of the magnitude divide.
module md_sign_fix
  import mult_div_pkg::*;
(
  input  logic [1:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] a_mag_o,
  output logic [31:0] b_mag_o,
  output logic        a_neg_o,
  output logic        b_neg_o,
  input  logic [1:0]  rop_i,
  input  logic        rneg_a_i,
  input  logic        rneg_b_i,
  input  logic [63:0] raw_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic        sgn;
  logic [63:0] prod;
  logic [31:0] quo, rem;

  assign sgn     = (op_i == OP_MULT) || (op_i == OP_DIV);
  assign a_neg_o = sgn & a_i[31];
  assign b_neg_o = sgn & b_i[31];
  assign a_mag_o = a_neg_o ? (~a_i + 32'd1) : a_i;
  assign b_mag_o = b_neg_o ? (~b_i + 32'd1) : b_i;

  // Product and quotient negate on differing signs; remainder follows the
  // dividend. 0x80000000 / -1 falls out naturally as 0x80000000 rem 0.
  always_comb begin
    prod = (rneg_a_i ^ rneg_b_i) ? (~raw_i + 64'd1) : raw_i;
    quo  = (rneg_a_i ^ rneg_b_i) ? (~raw_i[31:0] + 32'd1) : raw_i[31:0];
    rem  = rneg_a_i ? (~raw_i[63:32] + 32'd1) : raw_i[63:32];
    if ((rop_i == OP_MULT) || (rop_i == OP_MULTU)) begin
      hi_o = prod[63:32];
      lo_o = prod[31:0];
    end else begin
      hi_o = rem;
      lo_o = quo;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit.
//   clk/reset      : rising-edge clock, synchronous active-high reset
//   start/op       : launch mult/multu/div/divu on In2 ($rs) and In1 ($rt)
//   hi_we/lo_we    : mthi/mtlo from wdata, honoured only when idle
//   hi/lo          : architectural HI/LO
//   busy/done      : busy through RUN and DONE; done is a one-cycle pulse
//   div_zero       : divide by zero, qualified by done
// One radix-2 step per RUN cycle on operand magnitudes; sign correction is
// applied by md_sign_fix as the last step is written into hi/lo.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int ITER = ITER_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] In2,
  input  logic [31:0] In1,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  localparam logic [5:0] LAST = 6'(ITER - 1);

  state_e      state_q;
  logic [63:0] acc_q, acc_d;
  logic [5:0]  cnt_q;
  logic [1:0]  op_q;
  logic [31:0] opnd_q;       // multiplicand or divisor magnitude
  logic        na_q, nb_q;
  logic [31:0] hi_q, lo_q;
  logic        busy_q, done_q, dz_q;

  logic [31:0] a_mag, b_mag, res_hi, res_lo;
  logic        a_neg, b_neg, op_is_div, run_div;
  logic [32:0] add_sum, sub_diff;

  assign op_is_div = (op == OP_DIV) || (op == OP_DIVU);
  assign run_div   = (op_q == OP_DIV) || (op_q == OP_DIVU);

  md_sign_fix u_fix (
    .op_i     (op),
    .a_i      (In2),
    .b_i      (In1),
    .a_mag_o  (a_mag),
    .b_mag_o  (b_mag),
    .a_neg_o  (a_neg),
    .b_neg_o  (b_neg),
    .rop_i    (op_q),
    .rneg_a_i (na_q),
    .rneg_b_i (nb_q),
    .raw_i    (acc_d),
    .hi_o     (res_hi),
    .lo_o     (res_lo)
  );

  // Multiply: acc = {partial, multiplier}; add on LSB, shift right with the
  //   33-bit sum so the carry is kept.
  // Divide: acc = {remainder, dividend/quotient}; shift left one, trial
  //   subtract from the top 33 bits, restore on borrow. The remainder stays
  //   below the divisor, so a successful difference fits in 32 bits.
  always_comb begin
    add_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    sub_diff = acc_q[63:31] - {1'b0, opnd_q};
    if (run_div)
      acc_d = sub_diff[32] ? {acc_q[62:0], 1'b0}
                           : {sub_diff[31:0], acc_q[30:0], 1'b1};
    else
      acc_d = {add_sum, acc_q[31:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      opnd_q  <= '0;
      na_q    <= 1'b0;
      nb_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            na_q   <= a_neg;
            nb_q   <= b_neg;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (op_is_div && (In1 == 32'd0)) begin
              state_q <= DONE;
              hi_q    <= In2;
              lo_q    <= '1;
              done_q  <= 1'b1;
              dz_q    <= 1'b1;
            end else begin
              state_q <= RUN;
              acc_q   <= {32'd0, op_is_div ? a_mag : b_mag};
              opnd_q  <= op_is_div ? b_mag : a_mag;
            end
          end else begin
            if (hi_we) hi_q <= wdata;
            if (lo_we) lo_q <= wdata;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == LAST) begin
            state_q <= DONE;
            hi_q    <= res_hi;
            lo_q    <= res_lo;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          dz_q    <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule
